// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared write-back select, load funct3 and stage state definitions
package rv_pkg;

  localparam int XLEN    = 32;
  localparam int WBSEL_W = 2;

  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_LOAD = 2'd1;
  localparam logic [1:0] WBSEL_PC4  = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_COMMIT   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends the addressed byte or half of a load word
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown size codes fall back to a full-word load.
  always_comb begin
    data = rdata;
    case (func3)
      FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: data = {24'd0, byte_sel};
      FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LHU: data = {16'd0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - one-entry write-back stage driving the register-file write port
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int WBSEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regwen,
  input  logic [4:0]         in_rd,
  input  logic [WBSEL_W-1:0] in_wbsel,
  input  logic [2:0]         in_func3,
  input  logic [1:0]         in_addr_lo,
  input  logic [XLEN-1:0]    in_alu_res,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               regWEn,
  output logic [4:0]         rd,
  output logic [XLEN-1:0]    WB_Data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  wb_state_t         state_q, state_d;
  logic              cap_regwen_q;
  logic [4:0]        cap_rd_q;
  logic [2:0]        cap_func3_q;
  logic [1:0]        cap_addr_lo_q;
  logic              regwen_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [XLEN-1:0]   load_data;
  logic              accept;
  logic              in_is_load;
  logic              load_done;

  assign in_ready   = (state_q != WB_WAIT_MEM);
  assign accept     = in_valid && in_ready;
  assign in_is_load = (in_wbsel == WBSEL_W'(WBSEL_LOAD));
  assign load_done  = (state_q == WB_WAIT_MEM) && mem_rvalid;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .func3   (cap_func3_q),
    .addr_lo (cap_addr_lo_q),
    .data    (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: begin
        if (accept) state_d = in_is_load ? WB_WAIT_MEM : WB_COMMIT;
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) state_d = WB_COMMIT;
      end
      WB_COMMIT: begin
        if (accept) state_d = in_is_load ? WB_WAIT_MEM : WB_COMMIT;
        else        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Output rd/WB_Data only change when a write is about to commit, so they
  // hold their last values while a load is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WB_IDLE;
      cap_regwen_q  <= 1'b0;
      cap_rd_q      <= 5'd0;
      cap_func3_q   <= 3'd0;
      cap_addr_lo_q <= 2'd0;
      regwen_q      <= 1'b0;
      rd_q          <= 5'd0;
      wb_data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cap_regwen_q  <= in_regwen;
        cap_rd_q      <= in_rd;
        cap_func3_q   <= in_func3;
        cap_addr_lo_q <= in_addr_lo;
        if (!in_is_load) begin
          regwen_q  <= in_regwen;
          rd_q      <= in_rd;
          wb_data_q <= (in_wbsel == WBSEL_W'(WBSEL_PC4)) ? in_pc_plus4 : in_alu_res;
        end
      end
      if (load_done) begin
        regwen_q  <= cap_regwen_q;
        rd_q      <= cap_rd_q;
        wb_data_q <= load_data;
      end
    end
  end

  assign regWEn  = (state_q == WB_COMMIT) && regwen_q && (rd_q != 5'd0);
  assign rd      = rd_q;
  assign WB_Data = wb_data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      retire_cnt_q <= 32'd0;
    else if (state_q == WB_COMMIT)   retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage (directed cases plus randomized traffic)
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwen;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_func3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc_plus4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        regWEn;
  logic [4:0]  rd;
  logic [31:0] WB_Data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regwen   (in_regwen),
    .in_rd       (in_rd),
    .in_wbsel    (in_wbsel),
    .in_func3    (in_func3),
    .in_addr_lo  (in_addr_lo),
    .in_alu_res  (in_alu_res),
    .in_pc_plus4 (in_pc_plus4),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .regWEn      (regWEn),
    .rd          (rd),
    .WB_Data     (WB_Data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the register file should receive for one instruction.
  function automatic logic [31:0] ref_data(input logic [1:0] wbsel, input logic [2:0] f3,
                                           input logic [1:0] a, input logic [31:0] alu,
                                           input logic [31:0] pc4, input logic [31:0] word);
    longint unsigned b, h;
    if (wbsel == 2'd2) return pc4;
    if (wbsel != 2'd1) return alu;
    b = (word >> (8 * a)) % 256;
    h = (word >> (16 * (a / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic drive_in(input logic v, input logic we, input logic [4:0] r, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [1:0] a,
                          input logic [31:0] alu, input logic [31:0] pc4);
    in_valid = v; in_regwen = we; in_rd = r; in_wbsel = sel;
    in_func3 = f3; in_addr_lo = a; in_alu_res = alu; in_pc_plus4 = pc4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One isolated instruction; the load response arrives after 'delay' stall cycles.
  task automatic run_txn(input string tag, input logic we, input logic [4:0] r, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] word, input int delay,
                         input logic [31:0] exp);
    drive_in(1'b1, we, r, sel, f3, a, alu, pc4);
    check({tag, "_rdy"}, in_ready, 1);
    step();
    drive_in(1'b0, $urandom_range(0, 1), 5'($urandom), 2'($urandom), 3'($urandom),
             2'($urandom), $urandom, $urandom);
    if (sel == 2'd1) begin
      for (int i = 0; i < delay; i++) begin
        check({tag, "_stall_rdy"}, in_ready, 0);
        check({tag, "_stall_we"}, regWEn, 0);
        mem_rdata = $urandom;
        step();
      end
      check({tag, "_wait_rdy"}, in_ready, 0);
      mem_rvalid = 1'b1;
      mem_rdata = word;
      step();
    end
    mem_rvalid = $urandom_range(0, 1);
    mem_rdata = $urandom;
    check({tag, "_we"}, regWEn, 32'(we && (r != 5'd0)));
    check({tag, "_rd"}, rd, 32'(r));
    check({tag, "_data"}, WB_Data, exp);
    step();
    mem_rvalid = 1'b0;
    check({tag, "_idle_we"}, regWEn, 0);
    check({tag, "_hold_data"}, WB_Data, exp);
  endtask

  initial begin
    logic [31:0] w;
    drive_in(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0);
    mem_rdata = 32'd0;
    do_reset();
    check("rst_we", regWEn, 0);
    check("rst_rd", rd, 0);
    check("rst_data", WB_Data, 0);
    check("rst_rdy", in_ready, 1);

    // Reset while a load is outstanding: the load must never write.
    drive_in(1'b1, 1'b1, 5'd3, 2'd1, 3'b010, 2'd0, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    check("rml_wait_rdy", in_ready, 0);
    step();
    rst_n = 1'b0;
    #2;
    check("rml_async_rdy", in_ready, 1);
    check("rml_async_we", regWEn, 0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("rml_late_we", regWEn, 0);
    check("rml_late_rdy", in_ready, 1);
    check("rml_late_data", WB_Data, 0);
    step();
    check("rml_late_we2", regWEn, 0);

    // Back-to-back ALU writes.
    drive_in(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h11, 32'h0);
    step();
    check("b2b0_we", regWEn, 1); check("b2b0_rd", rd, 5); check("b2b0_data", WB_Data, 32'h11);
    check("b2b0_rdy", in_ready, 1);
    drive_in(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h22, 32'h0);
    step();
    check("b2b1_we", regWEn, 1); check("b2b1_rd", rd, 6); check("b2b1_data", WB_Data, 32'h22);
    check("b2b1_rdy", in_ready, 1);
    drive_in(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h33, 32'h0);
    step();
    check("b2b2_we", regWEn, 1); check("b2b2_rd", rd, 7); check("b2b2_data", WB_Data, 32'h33);
    check("b2b2_rdy", in_ready, 1);
    in_valid = 1'b0;
    step();
    check("b2b_end_we", regWEn, 0);
    check("b2b_end_rd", rd, 7);

    // Load formatting with fixed word.
    w = 32'h80F0_7F81;
    run_txn("lb0",  1'b1, 5'd8, 2'd1, 3'b000, 2'd0, 0, 0, w, 1, 32'hFFFF_FF81);
    run_txn("lbu3", 1'b1, 5'd8, 2'd1, 3'b100, 2'd3, 0, 0, w, 0, 32'h0000_0080);
    run_txn("lh1",  1'b1, 5'd8, 2'd1, 3'b001, 2'd2, 0, 0, w, 2, 32'hFFFF_80F0);
    run_txn("lhu0", 1'b1, 5'd8, 2'd1, 3'b101, 2'd0, 0, 0, w, 0, 32'h0000_7F81);
    run_txn("lw",   1'b1, 5'd8, 2'd1, 3'b010, 2'd1, 0, 0, w, 1, 32'h80F0_7F81);

    // Load stall with the next instruction waiting on the input.
    drive_in(1'b1, 1'b1, 5'd10, 2'd1, 3'b010, 2'd0, 32'h0, 32'h0);
    step();
    drive_in(1'b1, 1'b1, 5'd9, 2'd0, 3'b000, 2'd3, 32'h99, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("stall_rdy", in_ready, 0);
      check("stall_we", regWEn, 0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    check("stall_ld_we", regWEn, 1); check("stall_ld_rd", rd, 10);
    check("stall_ld_data", WB_Data, 32'h1234_5678); check("stall_ld_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("stall_alu_we", regWEn, 1); check("stall_alu_rd", rd, 9);
    check("stall_alu_data", WB_Data, 32'h99);
    step();
    check("stall_end_we", regWEn, 0);

    // x0 destination and PC+4 select.
    run_txn("jal_x0", 1'b1, 5'd0, 2'd2, 3'd0, 2'd0, 32'hAAAA_AAAA, 32'h104, 0, 0, 32'h104);
    run_txn("jal_x1", 1'b1, 5'd1, 2'd2, 3'd0, 2'd0, 32'hAAAA_AAAA, 32'h104, 0, 0, 32'h104);
    run_txn("sel3",   1'b1, 5'd4, 2'd3, 3'd0, 2'd0, 32'h5555_0001, 32'h104, 0, 0, 32'h5555_0001);

    // Randomized traffic, with stray mem_rvalid pulses while idle.
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [4:0]  r;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] alu, pc4, word;
      int          dly;
      we = $urandom_range(0, 3) != 0;
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      sel = 2'($urandom);
      f3 = 3'($urandom);
      a = 2'($urandom);
      alu = $urandom; pc4 = $urandom; word = $urandom;
      dly = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        check("rnd_idle_rv_we", regWEn, 0);
        check("rnd_idle_rv_rdy", in_ready, 1);
      end
      run_txn("rnd", we, r, sel, f3, a, alu, pc4, word, dly, ref_data(sel, f3, a, alu, pc4, word));
    end

`ifdef WB_RETIRE_CNT_EN
    do_reset();
    check("cnt_rst", retire_cnt, 0);
    run_txn("cnt0", 1'b1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h1, 0, 0, 0, 32'h1);
    run_txn("cnt1", 1'b0, 5'd3, 2'd0, 3'd0, 2'd0, 32'h2, 0, 0, 0, 32'h2);
    run_txn("cnt2", 1'b1, 5'd4, 2'd1, 3'b010, 2'd0, 0, 0, 32'h3, 2, 32'h3);
    check("cnt_three", retire_cnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
